// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared MMIO bus constants, address field slices and arbiter state encoding.
// Optional macro MMIO_ARB_LOCK_EN (used by the arbiter and its interface) enables bus locking.
package mmio_pkg;

  localparam int unsigned MMIO_ADDR_W = 21;
  localparam int unsigned MMIO_DATA_W = 32;

  // The MMIO controller decodes addr[10:5] as core and addr[4:0] as register.
  localparam int unsigned CORE_MSB = 10;
  localparam int unsigned CORE_LSB = 5;
  localparam int unsigned REG_MSB  = 4;
  localparam int unsigned REG_LSB  = 0;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_ACK
  } arb_state_t;

  function automatic logic [CORE_MSB-CORE_LSB:0] mmio_core_sel(input logic [MMIO_ADDR_W-1:0] addr);
    return addr[CORE_MSB:CORE_LSB];
  endfunction

  function automatic logic [REG_MSB-REG_LSB:0] mmio_reg_sel(input logic [MMIO_ADDR_W-1:0] addr);
    return addr[REG_MSB:REG_LSB];
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Request and MMIO bus signals between the masters/controller and the arbiter.
// MMIO_ARB_LOCK_EN adds the per-master req_lock signal.
interface mmio_bus_arbiter_if
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = MMIO_ADDR_W,
  parameter int unsigned DATA_W  = MMIO_DATA_W
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_wr;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wr_data;
`ifdef MMIO_ARB_LOCK_EN
  logic [NUM_REQ-1:0]             req_lock;
`endif
  logic [NUM_REQ-1:0]             req_ack;
  logic [DATA_W-1:0]              req_rd_data;
  logic [ID_W-1:0]                grant_id;
  logic                           busy;

  logic                           mmio_cs;
  logic                           mmio_wr;
  logic                           mmio_rd;
  logic [ADDR_W-1:0]              mmio_addr;
  logic [DATA_W-1:0]              mmio_wr_data;
  logic [DATA_W-1:0]              mmio_rd_data;

  // Requesting masters together with the MMIO controller side of the bus.
  modport master (
`ifdef MMIO_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_wr, req_addr, req_wr_data,
    input  req_ack, req_rd_data, grant_id, busy,
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output mmio_rd_data
  );

  modport slave (
`ifdef MMIO_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_wr, req_addr, req_wr_data,
    output req_ack, req_rd_data, grant_id, busy,
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  mmio_rd_data
  );

endinterface

// File: rtl/mmio_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid request strictly after ptr_i, wrapping,
// with ptr_i itself searched last.
module mmio_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               found_o
);

  int unsigned cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr_i) + i) % NUM_REQ;
      if (!found_o && valid_i[cand[ID_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter sharing one MMIO bus between NUM_REQ masters: IDLE -> ACCESS -> ACK.
// Define MMIO_ARB_LOCK_EN to let a master hold the bus across transactions via req_lock.
module mmio_bus_arbiter
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = MMIO_ADDR_W,
  parameter int unsigned DATA_W  = MMIO_DATA_W
) (
  input logic             clk,
  input logic             rst,
  mmio_bus_arbiter_if.slave bus
);

  localparam int unsigned     ID_W     = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] PTR_INIT = ID_W'(NUM_REQ - 1);

  arb_state_t         state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               cs_q;
  logic               wr_q;
  logic               rd_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] pick_valid;
  logic [ID_W-1:0]    win;
  logic               found;

`ifdef MMIO_ARB_LOCK_EN
  logic lock_q;
  logic lat_lock_q;

  // While locked only the holder (the last winner, ptr_q) may be granted.
  assign pick_valid = lock_q
                    ? (bus.req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << ptr_q))
                    : bus.req_valid;
`else
  assign pick_valid = bus.req_valid;
`endif

  mmio_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .valid_i (pick_valid),
    .ptr_i   (ptr_q),
    .idx_o   (win),
    .found_o (found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= PTR_INIT;
      grant_id_q <= '0;
      ack_q      <= '0;
      rd_data_q  <= '0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
`ifdef MMIO_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lat_lock_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (found) begin
            ptr_q      <= win;
            grant_id_q <= win;
            cs_q       <= 1'b1;
            wr_q       <= bus.req_wr[win];
            rd_q       <= ~bus.req_wr[win];
            addr_q     <= bus.req_addr[win];
            wdata_q    <= bus.req_wr_data[win];
            busy_q     <= 1'b1;
`ifdef MMIO_ARB_LOCK_EN
            lat_lock_q <= bus.req_lock[win];
`endif
            state_q    <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          cs_q              <= 1'b0;
          wr_q              <= 1'b0;
          rd_q              <= 1'b0;
          addr_q            <= '0;
          wdata_q           <= '0;
          rd_data_q         <= wr_q ? '0 : bus.mmio_rd_data;
          ack_q[grant_id_q] <= 1'b1;
`ifdef MMIO_ARB_LOCK_EN
          lock_q            <= lat_lock_q;
`endif
          state_q           <= ARB_ACK;
        end
        ARB_ACK: begin
          ack_q     <= '0;
          rd_data_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.req_ack      = ack_q;
  assign bus.req_rd_data  = rd_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.busy         = busy_q;
  assign bus.mmio_cs      = cs_q;
  assign bus.mmio_wr      = wr_q;
  assign bus.mmio_rd      = rd_q;
  assign bus.mmio_addr    = addr_q;
  assign bus.mmio_wr_data = wdata_q;

endmodule
